// File: rtl/data_mem_resp_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
// FSM state encodings live inside data_mem_resp itself.
package data_mem_resp_pkg;

   localparam int DATA_W = 32;
   localparam int LANE_W = 8;
   localparam int LANES  = DATA_W / LANE_W;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [LANES-1:0]  sel;
      logic [DATA_W-1:0] data;
   } mem_req_t;

   // Any address bit above the word index marks the access as out of range.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << (addr_w + 2);
      return |(addr & mask);
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data array built from four byte-lane memories with per-lane
// write enables and one combinational read port sharing the write address.
module data_mem_array
   import data_mem_resp_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [LANES-1:0]  we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [LANE_W-1:0] lane_mem [DEPTH];

      // NOTE: storage has no reset; clearing 2^ADDR_W words is neither wanted nor cheap.
      always_ff @(posedge clk) begin
         if (we[i]) lane_mem[addr] <= wdata[LANE_W*i +: LANE_W];
      end

      assign rdata[LANE_W*i +: LANE_W] = lane_mem[addr];
   end

endmodule

// File: rtl/data_mem_resp.sv
// Data-RAM responder: services ce/we/sel requests after WAIT_CYCLES wait states
// and raises a stall request towards ctrl until each access completes.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [LANES-1:0]  sel_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              stallreq_o,
   output logic              addr_err_o
);

   logic [LANES-1:0]  mem_we;
   logic [ADDR_W-1:0] mem_idx;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   data_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_idx),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   if (WAIT_CYCLES == 0) begin : g_nowait
      logic live_oor;
      logic unused_rst;

      assign live_oor   = addr_out_of_range(addr_i, ADDR_W);
      assign unused_rst = rst;

      assign mem_idx    = addr_i[ADDR_W+1:2];
      assign mem_wdata  = data_i;
      assign mem_we     = (ce_i & we_i & ~live_oor) ? sel_i : '0;
      assign data_o     = (ce_i & ~we_i & ~live_oor) ? mem_rdata : '0;
      assign stallreq_o = 1'b0;
      assign addr_err_o = ce_i & live_oor;
   end else begin : g_wait
      typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

      state_t      state;
      logic [2:0]  cnt;
      mem_req_t    live_req;
      mem_req_t    req_q;
      mem_req_t    cur_req;
      logic        cur_oor;
      logic        commit;
      logic [DATA_W-1:0] rd_q;
      logic        err_q;

      assign live_req = '{we: we_i, addr: addr_i, sel: sel_i, data: data_i};

      // The request being serviced is the live one in IDLE, the latched one afterwards.
      always_comb begin
         // NOTE: every always_comb output is assigned up front so no path infers a latch.
         cur_req = (state == S_IDLE) ? live_req : req_q;
         cur_oor = addr_out_of_range(cur_req.addr, ADDR_W);
         commit  = ce_i & (((state == S_IDLE) & (WAIT_CYCLES == 1)) |
                           ((state == S_WAIT) & (cnt == 3'd0)));
         mem_we  = (commit & cur_req.we & ~cur_oor) ? cur_req.sel : '0;
      end

      assign mem_idx   = cur_req.addr[ADDR_W+1:2];
      assign mem_wdata = cur_req.data;

      // NOTE: sequential state uses non-blocking assignments only.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            req_q <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (ce_i) begin
                     req_q <= live_req;
                     if (WAIT_CYCLES == 1) begin
                        rd_q  <= (~live_req.we & ~cur_oor) ? mem_rdata : '0;
                        err_q <= cur_oor;
                        state <= S_DONE;
                     end else begin
                        cnt   <= 3'(WAIT_CYCLES - 2);
                        state <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (!ce_i) begin
                     state <= S_IDLE;
                  end else if (cnt == 3'd0) begin
                     rd_q  <= (~req_q.we & ~cur_oor) ? mem_rdata : '0;
                     err_q <= cur_oor;
                     state <= S_DONE;
                  end else begin
                     cnt <= cnt - 3'd1;
                  end
               end
               S_DONE: begin
                  rd_q  <= '0;
                  err_q <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end

      // Combinational so ctrl stalls in the request cycle itself.
      assign stallreq_o = ce_i & (state != S_DONE);
      assign data_o     = rd_q;
      assign addr_err_o = err_q;
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp at WAIT_CYCLES of 2, 4 and 0.
module tb_data_mem_resp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic        rst2, ce2, we2, stall2, err2;
   logic [31:0] addr2, din2, dout2;
   logic [3:0]  sel2;

   logic        rst4, ce4, we4, stall4, err4;
   logic [31:0] addr4, din4, dout4;
   logic [3:0]  sel4;

   logic        rst0, ce0, we0, stall0, err0;
   logic [31:0] addr0, din0, dout0;
   logic [3:0]  sel0;

   data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst2), .ce_i(ce2), .we_i(we2), .addr_i(addr2), .sel_i(sel2),
      .data_i(din2), .data_o(dout2), .stallreq_o(stall2), .addr_err_o(err2));

   data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(rst4), .ce_i(ce4), .we_i(we4), .addr_i(addr4), .sel_i(sel4),
      .data_i(din4), .data_o(dout4), .stallreq_o(stall4), .addr_err_o(err4));

   data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst0), .ce_i(ce0), .we_i(we0), .addr_i(addr0), .sel_i(sel0),
      .data_i(din0), .data_o(dout0), .stallreq_o(stall0), .addr_err_o(err0));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // One full W=2 access; inputs are scrambled during WAIT to prove they are latched.
   task automatic access2(input string tag, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_err);
      @(negedge clk);
      ce2 = 1'b1; we2 = w; addr2 = a; sel2 = s; din2 = d;
      #1;
      check({tag, ".stall_c0"}, 32'(stall2), 32'd1);
      check({tag, ".data_c0"}, dout2, 32'd0);
      @(negedge clk);
      we2 = ~w; addr2 = a ^ 32'h40; sel2 = ~s; din2 = ~d;
      #1;
      check({tag, ".stall_c1"}, 32'(stall2), 32'd1);
      @(negedge clk);
      #1;
      check({tag, ".stall_done"}, 32'(stall2), 32'd0);
      check({tag, ".data_done"}, dout2, exp_d);
      check({tag, ".err_done"}, 32'(err2), 32'(exp_err));
      ce2 = 1'b0;
      @(negedge clk);
      #1;
      check({tag, ".data_idle"}, dout2, 32'd0);
      check({tag, ".err_idle"}, 32'(err2), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst2 = 1'b1; ce2 = 1'b0; we2 = 1'b0; addr2 = '0; sel2 = '0; din2 = '0;
      rst4 = 1'b1; ce4 = 1'b0; we4 = 1'b0; addr4 = '0; sel4 = '0; din4 = '0;
      rst0 = 1'b1; ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; din0 = '0;
      #1;
      check("rst.data", dout2, 32'd0);
      check("rst.stall", 32'(stall2), 32'd0);
      check("rst.err", 32'(err2), 32'd0);
      check("rst4.data", dout4, 32'd0);
      @(negedge clk);
      rst2 = 1'b0; rst4 = 1'b0; rst0 = 1'b0;

      // W=2: full write then read back
      access2("wr10", 1'b1, 32'h10, 4'b1111, 32'h1234_5678, 32'd0, 1'b0);
      access2("rd10", 1'b0, 32'h10, 4'b0001, 32'h0, 32'h1234_5678, 1'b0);

      // Byte lane: only data[23:16] replaced
      access2("wr_lane", 1'b1, 32'h10, 4'b0100, 32'hAABB_CCDD, 32'd0, 1'b0);
      access2("rd_lane", 1'b0, 32'h10, 4'b0000, 32'h0, 32'h12BB_5678, 1'b0);

      // Flush: ce drops during WAIT, write must not land
      access2("wr20", 1'b1, 32'h20, 4'b1111, 32'h0BAD_F00D, 32'd0, 1'b0);
      @(negedge clk);
      ce2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; sel2 = 4'hF; din2 = 32'hFFFF_FFFF;
      #1;
      check("flush.stall_c0", 32'(stall2), 32'd1);
      @(negedge clk);
      #1;
      check("flush.stall_wait", 32'(stall2), 32'd1);
      ce2 = 1'b0;
      #1;
      check("flush.stall_drop", 32'(stall2), 32'd0);
      @(negedge clk);
      #1;
      check("flush.data_idle", dout2, 32'd0);
      access2("rd20", 1'b0, 32'h20, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0);

      // Out of range: word 0 aliases 0x1000 in the index bits
      access2("wr0", 1'b1, 32'h0, 4'b1111, 32'h55AA_55AA, 32'd0, 1'b0);
      access2("rd_oor", 1'b0, 32'h1000, 4'b1111, 32'h0, 32'd0, 1'b1);
      access2("wr_oor", 1'b1, 32'h1000, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b1);
      access2("rd0", 1'b0, 32'h0, 4'b1111, 32'h0, 32'h55AA_55AA, 1'b0);

      // W=4: commit a known value, then reset in the second WAIT cycle of a write
      @(negedge clk);
      ce4 = 1'b1; we4 = 1'b1; addr4 = 32'h40; sel4 = 4'hF; din4 = 32'h1111_1111;
      repeat (3) @(negedge clk);
      #1;
      check("w4.stall_c3", 32'(stall4), 32'd1);
      @(negedge clk);
      #1;
      check("w4.stall_done", 32'(stall4), 32'd0);
      ce4 = 1'b0;
      @(negedge clk);
      ce4 = 1'b1; we4 = 1'b1; addr4 = 32'h40; sel4 = 4'hF; din4 = 32'h2222_2222;
      repeat (2) @(negedge clk);
      #1;
      rst4 = 1'b1; ce4 = 1'b0;
      #1;
      check("w4rst.data", dout4, 32'd0);
      check("w4rst.stall", 32'(stall4), 32'd0);
      check("w4rst.err", 32'(err4), 32'd0);
      @(negedge clk);
      rst4 = 1'b0;
      @(negedge clk);
      ce4 = 1'b1; we4 = 1'b0; addr4 = 32'h40;
      repeat (4) @(negedge clk);
      #1;
      check("w4.rd_done", dout4, 32'h1111_1111);
      check("w4.rd_stall", 32'(stall4), 32'd0);
      ce4 = 1'b0;

      // W=0: write commits at the edge, read is same-cycle
      @(negedge clk);
      ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; sel0 = 4'hF; din0 = 32'hCAFE_F00D;
      #1;
      check("w0.wr_stall", 32'(stall0), 32'd0);
      check("w0.wr_data", dout0, 32'd0);
      @(negedge clk);
      we0 = 1'b0; sel0 = 4'b0001;
      #1;
      check("w0.rd_data", dout0, 32'hCAFE_F00D);
      check("w0.rd_stall", 32'(stall0), 32'd0);
      @(negedge clk);
      addr0 = 32'h1000;
      #1;
      check("w0.oor_data", dout0, 32'd0);
      check("w0.oor_err", 32'(err0), 32'd1);
      @(negedge clk);
      ce0 = 1'b0; addr0 = 32'h10;
      #1;
      check("w0.idle_data", dout0, 32'd0);
      check("w0.idle_err", 32'(err0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Wait-state data-memory responder for the core's data-RAM port: accepts the single-cycle chip-enable/write-enable/byte-select requests the memory stage issues, services them from an internal word-organised array after a fixed number of wait states, and holds the pipeline via a stall request into the ctrl block until each access completes. It sits outside the core, on the `ram_*` pins, with `stallreq_o` wired to ctrl as the memory-stage stall source.

## Interface
- `ADDR_W`, 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: stall cycles per access, legal 0..7.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset is asynchronous and active-high.
- `ce_i`  in  1  access request (core `ram_ce_o`).
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  32  byte address; `[1:0]` ignored.
- `sel_i`  in  4  byte-lane enables; `sel_i[3]` = `data[31:24]` = lowest byte address (big-endian).
- `data_i`  in  32  write data.
- `data_o`  out  32  read data.
- `stallreq_o`  out  1  stall request to ctrl.
- `addr_err_o`  out  1  out-of-range access flag.

## Operation
- **Word index and range check**
  - Word index = `addr_i[ADDR_W+1:2]`.
  - Out of range = any bit of `addr_i[31:ADDR_W+2]` set.
- **Writes**
  - Each lane `i` with `sel_i[i]=1` is updated.
  - Lanes with `sel_i[i]=0` are untouched.
- **Reads**
  - Return the full word regardless of `sel_i`; lane extraction belongs to the mem stage.
- **Out-of-range access**
  - Write is suppressed.
  - Read returns 0.
  - `addr_err_o`=1 for the completion cycle only.
- **`WAIT_CYCLES`=0**
  - No FSM activity.
  - Read is combinational: `data_o` = `mem[idx]` while `ce_i & ~we_i`, else 0.
  - Write commits at the edge ending the request cycle.
  - `stallreq_o`≡0.
- **`WAIT_CYCLES`≥1**: FSM with states IDLE, WAIT, DONE and a 3-bit counter `cnt`.
  - **IDLE, `ce_i`=1**: latch `we`/`addr`/`sel`/`data`.
    - If `WAIT_CYCLES`=1: commit (write, or register read word) and go to DONE.
    - Else: `cnt`←`WAIT_CYCLES`−2 and go to WAIT.
  - **WAIT**
    - `ce_i`=0: abort to IDLE with no commit. This is the flush case.
    - `cnt`=0: commit latched request, go to DONE.
    - Otherwise decrement `cnt`.
  - **DONE**
    - `data_o` = registered read word (0 for writes and out-of-range reads).
    - `stallreq_o`=0.
    - Go to IDLE unconditionally.
  - `stallreq_o` = `ce_i & (state==IDLE | state==WAIT)`. It is combinational, so ctrl stalls in the request cycle itself.
  - `data_o`=0 in IDLE and WAIT.
- **Reset**
  - Reset forces IDLE, `cnt`=0, read register=0.
  - A pending write is discarded.
  - Array contents are not cleared by reset.

## Timing
- Reset values: `data_o`=0, `stallreq_o`=0 while `ce_i`=0, `addr_err_o`=0.
- Request in cycle 0 (`WAIT_CYCLES`=W≥1):
  - `stallreq_o`=1 in cycles 0..W−1.
  - DONE in cycle W, with `data_o` valid and `stallreq_o`=0.
  - Written data is visible to any read request in cycle W+1.
- Back-to-back requests are serviced one per W+1 cycles. A request presented during DONE is not accepted; it is re-presented in IDLE, which the ctrl stall guarantees.
- Inputs changing during WAIT are ignored; latched values are used.
- `ce_i` falling during WAIT: IDLE on the next edge, no memory change, `stallreq_o` drops immediately.

## Structure
- The shared `defines.v` gains `DataAddrBus`, `DataMemNum` (2^ADDR_W), `DataMemNumLog2`, reusing `RegBus`, `ChipEnable`, `WriteEnable`.
- FSM state encodings stay local to the block.
- One sub-module: `data_mem_array`.
  - Four 8-bit lane arrays.
  - Per-lane write enable.
  - One combinational read port.

## Test plan
- **Write then read, W=2**
  - Stimulus: write `0x12345678`, `sel`=`4'b1111` to addr `0x10`, then read `0x10`.
  - Required: `stallreq_o` high 2 cycles per access; DONE `data_o`=`0x12345678`.
- **Byte lanes**
  - Stimulus: write `0xAABBCCDD`, `sel`=`4'b0100` over `0x12345678` at `0x10`.
  - Required: read returns `0x12BB5678`.
- **Flush abort**
  - Stimulus: write `0xFFFFFFFF` to `0x20` with `ce_i` dropped in WAIT.
  - Required: `stallreq_o` falls the same cycle; later read of `0x20` returns the prior value.
- **Out of range, ADDR_W=10**
  - Stimulus: read `0x00001000`.
  - Required: DONE `data_o`=0 and `addr_err_o`=1 for exactly one cycle.
  - Stimulus: write to the same address.
  - Required: array unchanged.
- **Reset mid-wait, W=4**
  - Stimulus: assert `rst` in the second WAIT cycle of a write.
  - Required: outputs at reset values immediately; the write is not committed.
- **W=0**
  - Stimulus: read of `0x10` after a write.
  - Required: same-cycle `data_o`; `stallreq_o` never asserts.
